fetch: RTL and testbench
========================

# fetch

Instruction fetch stage that produces the `insn`/`pc`/`valid_insn` stream consumed by the decode stage. It owns the fetch PC and issues single-outstanding word reads to instruction memory over a req/ack handshake. Fetched words are registered toward decode and held under back-pressure through a one-entry skid buffer. Taken branches and jumps from later stages redirect the PC and squash any in-flight or buffered instruction.

## Interface
- `RESET_PC`, default 32'h80020000: fetch PC loaded on reset; must be word-aligned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode cannot accept; an instruction is accepted on cycles where `valid_insn && !stall`.
- `redirect`  in  1  single-cycle pulse; taken branch or jump.
- `redirect_pc`  in  [0:31]  new fetch address; bit 0 is the MSB, and bits [30:31] are ignored and treated as 0.
- `imem_req`  out  1  read request; registered.
- `imem_addr`  out  [0:31]  word address; registered; stable while `imem_req` is high.
- `imem_ack`  in  1  response valid; sampled only while `imem_req` is high.
- `imem_data`  in  [0:31]  instruction word; valid when `imem_ack` is high.
- `insn`  out  [0:31]  instruction to decode; registered.
- `pc`  out  [0:31]  address of `insn`; registered.
- `valid_insn`  out  1  `insn` and `pc` are valid; registered.

## Operation
**States:** IDLE, REQ, HOLD, FLUSH.

**Internal state:**
- `fetch_pc` [0:31].
- Skid buffer: `buf_insn` and `buf_pc`, plus flag `buf_valid`.
- `accept = valid_insn && !stall`.

**Reset:**
- State → IDLE; `fetch_pc` → RESET_PC.
- `imem_req` = 0, `imem_addr` = 0.
- `insn` = 0, `pc` = 0, `valid_insn` = 0.
- `buf_valid` = 0.

**IDLE:** go to REQ unconditionally; drive `imem_req` = 1 and `imem_addr` = `fetch_pc`.

**REQ, no ack, no redirect:** hold `imem_req` and `imem_addr`.

**REQ, `imem_ack` = 1, no redirect:**
- `fetch_pc` += 4, wrapping modulo 2^32.
- If the output register is empty or `accept`:
  - Load `insn` = `imem_data`, `pc` = request address, `valid_insn` = 1.
  - Stay in REQ; `imem_addr` = new `fetch_pc`; `imem_req` stays 1.
- Otherwise:
  - Capture the word into the buffer; `buf_valid` = 1.
  - Go to HOLD; `imem_req` = 0.

**REQ, no ack, `accept`:** `valid_insn` = 0.

**HOLD:** on `accept`, move the buffer to the output register, set `buf_valid` = 0, go to REQ, and set `imem_req` = 1 at `fetch_pc`.

**Redirect (highest priority, overrides `stall`) — common effects:**
- `fetch_pc` = `redirect_pc` with bits [30:31] forced to 0.
- `valid_insn` = 0 and `buf_valid` = 0 next cycle.

**Redirect — state transition:**
- In REQ without ack: a request is still outstanding and cannot be withdrawn. Go to FLUSH; keep `imem_req` = 1 at the old address.
- In REQ with ack the same cycle: discard the data; go to REQ with `imem_addr` = redirect target.
- In HOLD or IDLE: go to REQ at the redirect target.

**FLUSH:**
- On `imem_ack`: discard the data; go to REQ at `fetch_pc`.
- A further redirect in FLUSH overwrites `fetch_pc` only.

**General:**
- An all-zero word (NOP) is forwarded like any other instruction.
- At most one request is outstanding.
- At most two instructions are held: output register plus buffer.
- Reset asserted in any state, including with a request outstanding, returns everything to reset values next cycle. The memory model must tolerate the dropped request.

## Timing
- First `imem_req` is high in the second cycle after `reset` deasserts (one IDLE cycle).
- Ack sampled at edge t → `valid_insn` high from t+1.
- A zero-wait-state memory (ack in the same cycle as req) yields one instruction per cycle with no bubbles while `stall` = 0.
- Stall at a single stall edge → the output register holds; at most one further word is captured into the buffer; `imem_req` drops the cycle after that capture.
- Release of stall → buffer goes to output on the accepting edge; `imem_req` rises the cycle after; no instruction is lost or duplicated.
- Redirect at edge t → `valid_insn` low at t+1.
  - If no request is outstanding: `imem_addr` = target at t+1.
  - If a request is outstanding: `imem_addr` = target the cycle after the flushed ack.

## Test plan
- **Reset, RESET_PC = 32'h80020000, ack every cycle:** `imem_addr` sequence 80020000, 80020004, 80020008; `valid_insn` high on consecutive cycles with `pc` matching.
- **Stall for 3 cycles mid-stream:** `insn` and `pc` stay frozen; exactly one word is buffered; `imem_req` is low during the stall; after release, `pc` continues +4 with no gap or duplicate.
- **Redirect to 32'h80021002 while a request is outstanding (ack 2 cycles later):** that ack's data is never presented; the next `imem_addr` is 80021000; the next `pc` out is 80021000.
- **Redirect in the same cycle as ack, with stall held high:** the acked word, the output word and the buffer word are all dropped; `valid_insn` = 0 next cycle; the request goes to the target.
- **`fetch_pc` = 32'hFFFFFFFC, ack:** next `imem_addr` = 32'h00000000.
- **Reset asserted in HOLD with the buffer full:** next cycle `valid_insn` = 0, `imem_req` = 0, `insn` = 0, `pc` = 0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word
// reads over imem_req/imem_ack, and feeds insn/pc/valid_insn to decode.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   stall            decode cannot accept this cycle
//   redirect         one-cycle taken branch/jump pulse
//   redirect_pc      new fetch address (bit 0 = MSB, low two bits ignored)
//   imem_req/addr    registered read request toward instruction memory
//   imem_ack/data    memory response, sampled only while imem_req is high
//   insn/pc/valid_insn  registered instruction bundle toward decode
module fetch #(
  parameter logic [0:31] RESET_PC = 32'h80020000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_data,
  output logic [0:31] insn,
  output logic [0:31] pc,
  output logic        valid_insn
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    FLUSH
  } state_e;

  state_e      state_q, state_d;
  logic [0:31] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [0:31] addr_q, addr_d;
  logic [0:31] insn_q, insn_d;
  logic [0:31] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [0:31] buf_insn_q, buf_insn_d;
  logic [0:31] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;

  logic        ack;
  logic        accept;
  logic [0:31] tgt;
  logic [0:31] pc_inc;
  logic        unused_lsbs;

  assign ack         = req_q && imem_ack;
  assign accept      = valid_q && !stall;
  assign tgt         = {redirect_pc[0:29], 2'b00};
  assign pc_inc      = fetch_pc_q + 32'd4;
  assign unused_lsbs = ^redirect_pc[30:31];

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    insn_d      = insn_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    buf_insn_d  = buf_insn_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        if (redirect) begin
          fetch_pc_d = tgt;
          addr_d     = tgt;
          valid_d    = 1'b0;
          buf_valid_d = 1'b0;
        end else begin
          addr_d = fetch_pc_q;
        end
      end

      REQ: begin
        if (redirect) begin
          fetch_pc_d  = tgt;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          if (ack) begin
            // Response lands with the redirect: drop it, go straight on.
            addr_d = tgt;
          end else begin
            // Outstanding read cannot be withdrawn; wait it out at old addr.
            state_d = FLUSH;
          end
        end else if (ack) begin
          fetch_pc_d = pc_inc;
          if (!valid_q || accept) begin
            insn_d  = imem_data;
            pc_d    = addr_q;
            valid_d = 1'b1;
            addr_d  = pc_inc;
          end else begin
            // Output is blocked: park the word and stop requesting.
            buf_insn_d  = imem_data;
            buf_pc_d    = addr_q;
            buf_valid_d = 1'b1;
            state_d     = HOLD;
            req_d       = 1'b0;
          end
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          fetch_pc_d  = tgt;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          state_d     = REQ;
          req_d       = 1'b1;
          addr_d      = tgt;
        end else if (accept) begin
          insn_d      = buf_insn_q;
          pc_d        = buf_pc_q;
          valid_d     = 1'b1;
          buf_valid_d = 1'b0;
          state_d     = REQ;
          req_d       = 1'b1;
          addr_d      = fetch_pc_q;
        end
      end

      FLUSH: begin
        if (redirect) begin
          fetch_pc_d = tgt;
        end
        if (ack) begin
          state_d = REQ;
          addr_d  = redirect ? tgt : fetch_pc_q;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= '0;
      insn_q      <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      buf_insn_q  <= '0;
      buf_pc_q    <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      insn_q      <= insn_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      buf_insn_q  <= buf_insn_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign insn       = insn_q;
  assign pc         = pc_q;
  assign valid_insn = valid_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed steps, then randomized
// stall/redirect/reset/latency traffic against a program-order model.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h80020000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [0:31] redirect_pc;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_ack;
  logic [0:31] imem_data;
  logic [0:31] insn;
  logic [0:31] pc;
  logic        valid_insn;

  int checks = 0;
  int failures = 0;
  int wait_left = 0;
  int lat_lo = 0;
  int lat_hi = 0;
  int n_acc = 0;

  logic [31:0] exp_pc;
  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  logic        held = 1'b0;
  logic [31:0] held_pc;
  logic [31:0] held_insn;

  fetch #(.RESET_PC(32'h80020000)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .insn(insn),
    .pc(pc),
    .valid_insn(valid_insn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a[5:2] == 4'hB) return 32'h0;
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs and the memory response at the falling edge,
  // score any accepted instruction, then advance past the rising edge.
  task automatic step(input logic rst, input logic st, input logic rd,
                      input logic [31:0] rpc);
    logic        req_b;
    logic        ack_b;
    logic [31:0] addr_b;
    @(negedge clk);
    if (pend) begin
      chk1("req_held", imem_req, 1'b1);
      chk("addr_held", imem_addr, pend_addr);
    end
    if (held) begin
      chk1("out_held_valid", valid_insn, 1'b1);
      chk("out_held_pc", pc, held_pc);
      chk("out_held_insn", insn, held_insn);
    end
    reset = rst;
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    if (imem_req === 1'b1 && wait_left == 0) begin
      imem_ack = 1'b1;
      imem_data = memf(imem_addr);
    end else begin
      imem_ack = 1'b0;
      imem_data = $urandom;
    end
    if (valid_insn === 1'b1 && !st) begin
      chk("acc_pc", pc, exp_pc);
      chk("acc_insn", insn, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (rd) exp_pc = {rpc[31:2], 2'b00};
    if (rst) exp_pc = RST_PC;
    req_b = imem_req;
    ack_b = imem_ack;
    addr_b = imem_addr;
    pend = (req_b === 1'b1) && !ack_b && !rst;
    pend_addr = addr_b;
    held = (valid_insn === 1'b1) && st && !rd && !rst;
    held_pc = pc;
    held_insn = insn;
    @(posedge clk);
    if (rst) wait_left = int'($urandom_range(lat_hi, lat_lo));
    else if (req_b === 1'b1 && ack_b)
      wait_left = int'($urandom_range(lat_hi, lat_lo));
    else if (req_b === 1'b1 && wait_left > 0) wait_left--;
    #1;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_ack = 1'b0;
    imem_data = '0;
    exp_pc = RST_PC;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_valid", valid_insn, 1'b0);
    chk("rst_insn", insn, 32'h0);
    chk("rst_pc", pc, 32'h0);

    // Zero-wait streaming after one IDLE cycle
    step(0, 0, 0, 0);
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h80020000);
    chk1("first_valid", valid_insn, 1'b0);
    step(0, 0, 0, 0);
    chk1("s1_valid", valid_insn, 1'b1);
    chk("s1_pc", pc, 32'h80020000);
    chk("s1_addr", imem_addr, 32'h80020004);
    step(0, 0, 0, 0);
    chk1("s2_valid", valid_insn, 1'b1);
    chk("s2_pc", pc, 32'h80020004);
    chk("s2_addr", imem_addr, 32'h80020008);

    // Three-cycle stall: one word buffered, request dropped
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk1("stall_req", imem_req, 1'b0);
      chk("stall_pc", pc, 32'h80020004);
    end
    step(0, 0, 0, 0);
    chk("rel_pc", pc, 32'h80020008);
    chk1("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 32'h8002000C);

    // Redirect with a request outstanding (two-cycle memory latency)
    lat_lo = 2;
    lat_hi = 2;
    step(0, 0, 0, 0);
    chk("pre_rd_pc", pc, 32'h8002000C);
    step(0, 0, 1, 32'h80021002);
    chk1("fl_valid", valid_insn, 1'b0);
    chk("fl_addr", imem_addr, 32'h80020010);
    step(0, 0, 0, 0);
    chk("fl_addr2", imem_addr, 32'h80020010);
    lat_lo = 0;
    lat_hi = 0;
    step(0, 0, 0, 0);
    chk1("fl_done_valid", valid_insn, 1'b0);
    chk("fl_done_addr", imem_addr, 32'h80021000);
    k = 0;
    while (valid_insn !== 1'b1 && k < 12) begin
      step(0, 0, 0, 0);
      k++;
    end
    chk1("rd_valid", valid_insn, 1'b1);
    chk("rd_pc", pc, 32'h80021000);

    // Redirect together with an ack while stalled
    step(0, 1, 1, 32'h80030008);
    chk1("rdack_valid", valid_insn, 1'b0);
    chk1("rdack_req", imem_req, 1'b1);
    chk("rdack_addr", imem_addr, 32'h80030008);
    step(0, 0, 0, 0);
    chk("rdack_pc", pc, 32'h80030008);

    // Redirect while the skid buffer is full
    step(0, 1, 0, 0);
    chk1("hold_req", imem_req, 1'b0);
    step(0, 1, 1, 32'h80040000);
    chk1("rdhold_valid", valid_insn, 1'b0);
    chk("rdhold_addr", imem_addr, 32'h80040000);
    step(0, 0, 0, 0);
    chk("rdhold_pc", pc, 32'h80040000);

    // Fetch PC wraps past the top of the address space
    step(0, 0, 1, 32'hFFFFFFFC);
    chk("wrap_addr0", imem_addr, 32'hFFFFFFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc0", pc, 32'hFFFFFFFC);
    chk("wrap_addr1", imem_addr, 32'h00000000);
    step(0, 0, 0, 0);
    chk("wrap_pc1", pc, 32'h00000000);

    // Reset in HOLD with the buffer full
    step(0, 1, 0, 0);
    chk1("prerst_req", imem_req, 1'b0);
    step(1, 1, 0, 0);
    chk1("hrst_valid", valid_insn, 1'b0);
    chk1("hrst_req", imem_req, 1'b0);
    chk("hrst_insn", insn, 32'h0);
    chk("hrst_pc", pc, 32'h0);
    step(0, 0, 0, 0);
    chk("restart_addr", imem_addr, 32'h80020000);
    step(0, 0, 0, 0);
    chk("restart_pc", pc, 32'h80020000);

    // Randomized traffic
    lat_lo = 0;
    lat_hi = 3;
    n_acc = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [31:0] t;
      r = int'($urandom_range(999, 0));
      t = $urandom;
      if (r % 3 == 0) t = 32'h80020000 | (t & 32'h0000_0FFF);
      else if (r % 3 == 1) t = 32'hFFFFFFE0 | (t & 32'h1F);
      step(r < 4, $urandom_range(99, 0) < 30, r >= 4 && r < 50, t);
    end
    chk1("progress", n_acc > 300, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
